// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared command type, queued entry layout and service FSM states.
package simple_bus_pkg;
    typedef logic [3:0] cmd_t;
    localparam cmd_t CMD_NOP = 4'h0;
    typedef struct packed {
        cmd_t        cmd;
        logic [15:0] saddr;
        logic        done;
    } entry_t;
    typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;
endpackage

// File: rtl/simple_bus_resp_fifo.sv
// simple_bus_resp_fifo: command queue with occupancy count and registered stall (high when full).
module simple_bus_resp_fifo
    import simple_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   empty,
    output logic   stall
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count, count_next;
    logic full, do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rptr];
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
    // stall is computed from the post-edge occupancy so it is exact on the cycle the FIFO fills
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            stall <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count_next;
            stall <= count_next == (AW+1)'(DEPTH);
        end
endmodule

// File: rtl/simple_bus_responder.sv
// simple_bus_responder: queues initiator commands, services each for SVC_LAT cycles, presents to backend.
// Define SIMPLE_BUS_RESP_STATS_EN to add saturating acc_cnt/stall_cnt statistics outputs.
module simple_bus_responder
    import simple_bus_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SVC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  cmd,
    input  logic [15:0] saddr,
    input  logic        done,
    output logic        stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_cmd,
    output logic [15:0] out_saddr,
    output logic        out_last
`ifdef SIMPLE_BUS_RESP_STATS_EN
    ,
    output logic [15:0] acc_cnt,
    output logic [15:0] stall_cnt
`endif
);
    state_t state, state_next;
    logic [3:0] svc_cnt, svc_next;
    logic push, pop, empty;
    entry_t head, hold;
    assign push = en && !stall && cmd != CMD_NOP;
    simple_bus_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata('{cmd: cmd, saddr: saddr, done: done}),
        .rdata(head),
        .empty(empty),
        .stall(stall)
    );
    always_comb begin
        state_next = state;
        svc_next = svc_cnt;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                svc_next = 4'(SVC_LAT - 1);
                state_next = WAIT;
            end
            WAIT: if (svc_cnt == 4'd0) state_next = PRESENT;
                  else svc_next = svc_cnt - 1'b1;
            PRESENT: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    assign out_valid = state == PRESENT;
    // out_* update only on entry to PRESENT so they hold the previous command through IDLE/WAIT
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            svc_cnt   <= '0;
            hold      <= '0;
            out_cmd   <= '0;
            out_saddr <= '0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_next;
            svc_cnt <= svc_next;
            if (pop) hold <= head;
            if (state == WAIT && state_next == PRESENT) {out_cmd, out_saddr, out_last} <= hold;
        end
`ifdef SIMPLE_BUS_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 1'b1;
            if (en && stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_simple_bus_responder.sv
// tb_simple_bus_responder: directed stimulus, queue-based reference model and literal spot checks.
module tb_simple_bus_responder;
    import simple_bus_pkg::*;
    localparam int DEPTH = 4;
    localparam int SVC_LAT = 2;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0, out_ready = 1'b1;
    logic [3:0] cmd = '0;
    logic [15:0] saddr = '0;
    logic stall, out_valid, out_last;
    logic [3:0] out_cmd;
    logic [15:0] out_saddr;
`ifdef SIMPLE_BUS_RESP_STATS_EN
    logic [15:0] acc_cnt, stall_cnt;
`endif
    int total = 0, passed = 0;

    simple_bus_responder #(.DEPTH(DEPTH), .SVC_LAT(SVC_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .saddr(saddr), .done(done),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_cmd(out_cmd), .out_saddr(out_saddr), .out_last(out_last)
`ifdef SIMPLE_BUS_RESP_STATS_EN
        , .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    // Reference model: a queue of waiting commands plus the one being serviced,
    // which becomes visible SVC_LAT edges after it leaves the queue.
    entry_t q[$];
    entry_t cur;
    bit busy = 0, pres = 0, m_stall = 0, accept;
    int ecnt = 0, pres_edge = 0, m_acc = 0, m_stc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            busy = 0; pres = 0; m_stall = 0; m_acc = 0; m_stc = 0;
        end else begin
            ecnt++;
            accept = en && !m_stall && cmd != 4'h0;
            if (en && m_stall && m_stc < 16'hFFFF) m_stc++;
            if (pres) begin
                if (out_ready) begin pres = 0; busy = 0; end
            end else if (busy) begin
                if (ecnt == pres_edge) pres = 1;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
                busy = 1;
                pres_edge = ecnt + SVC_LAT;
            end
            if (accept) begin
                q.push_back('{cmd: cmd, saddr: saddr, done: done});
                if (m_acc < 16'hFFFF) m_acc++;
            end
            m_stall = q.size() == DEPTH;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("stall", stall, m_stall);
        chk("out_valid", out_valid, pres);
        chk("count", dut.u_fifo.count, q.size());
        if (pres) begin
            chk("out_cmd", out_cmd, cur.cmd);
            chk("out_saddr", out_saddr, cur.saddr);
            chk("out_last", out_last, cur.done);
        end
`ifdef SIMPLE_BUS_RESP_STATS_EN
        chk("acc_cnt", acc_cnt, m_acc);
        chk("stall_cnt", stall_cnt, m_stc);
`endif
    end

    task automatic drive(input logic e, input logic [3:0] c, input logic [15:0] a, input logic d);
        en = e; cmd = c; saddr = a; done = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [3:0] c, input logic [15:0] a, input logic d);
        drive(1, c, a, d);
        next_cycle();
        drive(0, 4'h0, 16'h0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("single_valid", out_valid, k == 4);
            if (k == 4) begin
                chk("single_cmd", out_cmd, c);
                chk("single_saddr", out_saddr, a);
                chk("single_last", out_last, d);
            end
        end
    endtask

    initial begin
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_cmd", out_cmd, 0);
        chk("rst_saddr", out_saddr, 0);
        chk("rst_last", out_last, 0);
        next_cycle();
        rst = 1'b0;
        single(4'h3, 16'h1234, 1'b1);

        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 4'(i), 16'hA000 + 16'(i), 1'(i % 2));
            next_cycle();
        end
        drive(1, 4'h6, 16'hA006, 1'b0);
        @(negedge clk);
        chk("fill_stall", stall, 1);
        chk("fill_valid", out_valid, 1);
        chk("fill_cmd", out_cmd, 4'h1);
        repeat (7) next_cycle();
        @(negedge clk);
        chk("bp_stall", stall, 1);
        chk("bp_cmd", out_cmd, 4'h1);
        chk("bp_saddr", out_saddr, 16'hA001);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_stall", stall, 1);
        next_cycle();
        @(negedge clk);
        chk("bp_pop_stall", stall, 0);
        next_cycle();
        drive(0, 4'h0, 16'h0, 1'b0);
        out_ready = 1'b1;
        repeat (30) next_cycle();
        @(negedge clk);
        chk("drain_valid", out_valid, 0);
        chk("drain_count", dut.u_fifo.count, 0);

        drive(1, 4'h0, 16'hFFFF, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("nop_valid", out_valid, 0);
            chk("nop_stall", stall, 0);
            chk("nop_count", dut.u_fifo.count, 0);
        end
        next_cycle();
        drive(0, 4'h0, 16'h0, 1'b0);

        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(6 + i), 16'hC000 + 16'(i), 1'b1);
            next_cycle();
        end
        out_ready = 1'b1;
        drive(1, 4'hB, 16'hC005, 1'b0);
        next_cycle();
        out_ready = 1'b0;
        drive(0, 4'h0, 16'h0, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("wait_valid", out_valid, 0);
        chk("wait_count", dut.u_fifo.count, 3);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", dut.u_fifo.count, 0);
        chk("mid_rst_cmd", out_cmd, 0);
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        single(4'h5, 16'hBEEF, 1'b0);
        repeat (3) next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
